// File: rtl/axis_fifo.sv
// AXI-Stream FIFO with TKEEP/TLAST sideband and optional store-and-forward
// packet mode. Beats are held in a DEPTH-entry array and replayed in order.
module axis_fifo #(
  parameter int TDATA_BYTES = 1,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [TDATA_BYTES*8-1:0]   s_tdata,
  input  logic [TDATA_BYTES-1:0]     s_tkeep,
  input  logic                       s_tlast,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic [TDATA_BYTES*8-1:0]   m_tdata,
  output logic [TDATA_BYTES-1:0]     m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TDATA_BYTES * 9 + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic          wr_en, rd_en, full, empty;
  logic          wr_last, rd_last;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign s_tready = !areset && !full;

  assign {m_tdata, m_tkeep, m_tlast} = mem_q[rd_ptr_q];

  // Packet mode holds data back until a whole packet is stored; a full FIFO
  // releases an oversize packet so the producer can never deadlock.
  generate
    if (PACKET_MODE != 0) begin : g_pkt
      assign m_tvalid = !empty && ((pkt_count_q != '0) || full);
    end else begin : g_cut
      assign m_tvalid = !empty;
    end
  endgenerate

  assign wr_en   = s_tvalid && s_tready;
  assign rd_en   = m_tvalid && m_tready;
  assign wr_last = wr_en && s_tlast;
  assign rd_last = rd_en && m_tlast;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pkt_count_d = pkt_count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case ({wr_last, rd_last})
      2'b10:   pkt_count_d = pkt_count_q + CW'(1);
      2'b01:   pkt_count_d = pkt_count_q - CW'(1);
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {s_tdata, s_tkeep, s_tlast};
  end

  assign count     = count_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axis_fifo.sv
// Bench for axis_fifo: a cut-through and a packet-mode instance, each checked
// every cycle against a queue-based model of the stored stream.
module tb_axis_fifo;

  localparam int DEPTH = 16;
  localparam int TB    = 4;

  typedef logic [36:0] beat_t;
  typedef beat_t beat_q_t[$];
  typedef logic [48:0] snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ct_rst, ct_s_tlast, ct_s_tvalid, ct_s_tready, ct_m_tlast, ct_m_tvalid, ct_m_tready;
  logic [31:0] ct_s_tdata, ct_m_tdata;
  logic [3:0]  ct_s_tkeep, ct_m_tkeep;
  logic [4:0]  ct_count, ct_pkt_count;
  logic        pm_rst, pm_s_tlast, pm_s_tvalid, pm_s_tready, pm_m_tlast, pm_m_tvalid, pm_m_tready;
  logic [31:0] pm_s_tdata, pm_m_tdata;
  logic [3:0]  pm_s_tkeep, pm_m_tkeep;
  logic [4:0]  pm_count, pm_pkt_count;

  axis_fifo #(.TDATA_BYTES(TB), .DEPTH(DEPTH), .PACKET_MODE(0)) u_ct (
    .aclk(clk), .areset(ct_rst),
    .s_tdata(ct_s_tdata), .s_tkeep(ct_s_tkeep), .s_tlast(ct_s_tlast),
    .s_tvalid(ct_s_tvalid), .s_tready(ct_s_tready),
    .m_tdata(ct_m_tdata), .m_tkeep(ct_m_tkeep), .m_tlast(ct_m_tlast),
    .m_tvalid(ct_m_tvalid), .m_tready(ct_m_tready),
    .count(ct_count), .pkt_count(ct_pkt_count)
  );

  axis_fifo #(.TDATA_BYTES(TB), .DEPTH(DEPTH), .PACKET_MODE(1)) u_pm (
    .aclk(clk), .areset(pm_rst),
    .s_tdata(pm_s_tdata), .s_tkeep(pm_s_tkeep), .s_tlast(pm_s_tlast),
    .s_tvalid(pm_s_tvalid), .s_tready(pm_s_tready),
    .m_tdata(pm_m_tdata), .m_tkeep(pm_m_tkeep), .m_tlast(pm_m_tlast),
    .m_tvalid(pm_m_tvalid), .m_tready(pm_m_tready),
    .count(pm_count), .pkt_count(pm_pkt_count)
  );

  int errors = 0;
  int checks = 0;

  beat_q_t q_ct;
  beat_q_t q_pm;

  // Beats actually handed out by each DUT
  int    ct_out_n = 0;
  int    pm_out_n = 0;
  beat_t ct_out_last;
  beat_t pm_out_last;

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
    return {d, k, l};
  endfunction

  function automatic int n_last(input beat_q_t q);
    int n = 0;
    foreach (q[i]) if (q[i][0]) n++;
    return n;
  endfunction

  function automatic bit ct_vexp();
    return q_ct.size() != 0;
  endfunction

  function automatic bit pm_vexp();
    return (q_pm.size() != 0) && (n_last(q_pm) != 0 || q_pm.size() == DEPTH);
  endfunction

  function automatic snap_t ct_exp();
    beat_t h = ct_vexp() ? q_ct[0] : '0;
    return {!ct_rst && (q_ct.size() != DEPTH), ct_vexp(), 5'(q_ct.size()), 5'(n_last(q_ct)), h};
  endfunction

  function automatic snap_t pm_exp();
    beat_t h = pm_vexp() ? q_pm[0] : '0;
    return {!pm_rst && (q_pm.size() != DEPTH), pm_vexp(), 5'(q_pm.size()), 5'(n_last(q_pm)), h};
  endfunction

  function automatic snap_t ct_obs();
    beat_t h = ct_vexp() ? {ct_m_tdata, ct_m_tkeep, ct_m_tlast} : '0;
    return {ct_s_tready, ct_m_tvalid, ct_count, ct_pkt_count, h};
  endfunction

  function automatic snap_t pm_obs();
    beat_t h = pm_vexp() ? {pm_m_tdata, pm_m_tkeep, pm_m_tlast} : '0;
    return {pm_s_tready, pm_m_tvalid, pm_count, pm_pkt_count, h};
  endfunction

  task automatic ct_drive(input bit v, input beat_t b, input bit r);
    ct_s_tvalid = v;
    {ct_s_tdata, ct_s_tkeep, ct_s_tlast} = b;
    ct_m_tready = r;
    #1;
  endtask

  task automatic pm_drive(input bit v, input beat_t b, input bit r);
    pm_s_tvalid = v;
    {pm_s_tdata, pm_s_tkeep, pm_s_tlast} = b;
    pm_m_tready = r;
    #1;
  endtask

  // Advance one clock and apply the handshake rules to both models.
  task automatic tick();
    bit cw, cr, pw, pr, chs, phs;
    beat_t cb, pb, cob, pob, tmp;
    cw  = ct_s_tvalid && !ct_rst && (q_ct.size() != DEPTH);
    cr  = ct_vexp() && ct_m_tready;
    pw  = pm_s_tvalid && !pm_rst && (q_pm.size() != DEPTH);
    pr  = pm_vexp() && pm_m_tready;
    cb  = {ct_s_tdata, ct_s_tkeep, ct_s_tlast};
    pb  = {pm_s_tdata, pm_s_tkeep, pm_s_tlast};
    chs = ct_m_tvalid && ct_m_tready && !ct_rst;
    phs = pm_m_tvalid && pm_m_tready && !pm_rst;
    cob = {ct_m_tdata, ct_m_tkeep, ct_m_tlast};
    pob = {pm_m_tdata, pm_m_tkeep, pm_m_tlast};
    @(posedge clk);
    if (ct_rst) q_ct.delete();
    else begin
      if (cr) tmp = q_ct.pop_front();
      if (cw) q_ct.push_back(cb);
    end
    if (pm_rst) q_pm.delete();
    else begin
      if (pr) tmp = q_pm.pop_front();
      if (pw) q_pm.push_back(pb);
    end
    if (chs) begin
      ct_out_n++; ct_out_last = cob;
      $display("ct out data=%08h keep=%h last=%b", cob[36:5], cob[4:1], cob[0]);
    end
    if (phs) begin
      pm_out_n++; pm_out_last = pob;
      $display("pm out data=%08h keep=%h last=%b", pob[36:5], pob[4:1], pob[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      ct_drive(0, '0, 0);
      pm_drive(0, '0, 0);
      checks++;
      if (ct_s_tready !== 1'b0 || pm_s_tready !== 1'b0) begin
        errors++; $display("FAIL reset_ready ct=%b pm=%b required 0", ct_s_tready, pm_s_tready);
      end
      checks++;
      if (ct_obs() !== ct_exp() || pm_obs() !== pm_exp()) begin
        errors++; $display("FAIL reset_state ct=%h pm=%h required ct=%h pm=%h", ct_obs(), pm_obs(), ct_exp(), pm_exp());
      end
      tick();
    end
    ct_rst = 1'b0;
    pm_rst = 1'b0;
    ct_drive(0, '0, 0);
    checks++;
    if (ct_s_tready !== 1'b1 || pm_s_tready !== 1'b1) begin
      errors++; $display("FAIL reset_release ct=%b pm=%b required 1", ct_s_tready, pm_s_tready);
    end
    tick();
  endtask

  task automatic test_cut_through();
    int peak = 0;
    int base = ct_out_n;
    for (int i = 0; i < 12; i++) begin
      if (i < 5) ct_drive(1, mk(32'(i + 1), 4'hF, 1'b0), 1);
      else ct_drive(0, '0, 1);
      if (int'(ct_count) > peak) peak = int'(ct_count);
      checks++;
      if (ct_obs() !== ct_exp()) begin
        errors++; $display("FAIL cut_through cyc=%0d got=%h required=%h", i, ct_obs(), ct_exp());
      end
      tick();
    end
    checks++;
    if (peak !== 1 || ct_out_n - base !== 5 || ct_out_last[36:5] !== 32'd5) begin
      errors++; $display("FAIL cut_through_summary peak=%0d beats=%0d lastdata=%0h required 1 5 5", peak, ct_out_n - base, ct_out_last[36:5]);
    end
  endtask

  task automatic test_fill_wrap();
    int idx = 0;
    int base = ct_out_n;
    for (int i = 0; i < 16; i++) begin
      ct_drive(1, mk(32'(100 + idx), 4'hF, 1'(idx % 5 == 4)), 0);
      if (q_ct.size() != DEPTH) idx++;
      checks++;
      if (ct_obs() !== ct_exp()) begin
        errors++; $display("FAIL fill cyc=%0d got=%h required=%h", i, ct_obs(), ct_exp());
      end
      tick();
    end
    ct_drive(1, mk(32'(100 + idx), 4'hF, 1'b0), 0);
    checks++;
    if (ct_count !== 5'd16 || ct_s_tready !== 1'b0) begin
      errors++; $display("FAIL full_state count=%0d ready=%b required 16 0", ct_count, ct_s_tready);
    end
    tick();
    checks++;
    if (ct_count !== 5'd16) begin
      errors++; $display("FAIL full_no_write count=%0d required 16", ct_count);
    end
    for (int c = 0; c < 400 && idx < 56; c++) begin
      ct_drive(1, mk(32'(100 + idx), 4'hF, 1'(idx % 5 == 4)), 1'(c % 2 == 0));
      if (q_ct.size() != DEPTH) idx++;
      checks++;
      if (ct_obs() !== ct_exp()) begin
        errors++; $display("FAIL wrap cyc=%0d got=%h required=%h", c, ct_obs(), ct_exp());
      end
      tick();
    end
    for (int c = 0; c < 100 && q_ct.size() != 0; c++) begin
      ct_drive(0, '0, 1);
      checks++;
      if (ct_obs() !== ct_exp()) begin
        errors++; $display("FAIL wrap_drain cyc=%0d got=%h required=%h", c, ct_obs(), ct_exp());
      end
      tick();
    end
    checks++;
    if (ct_out_n - base !== 56 || ct_out_last[36:5] !== 32'd155 || ct_count !== 5'd0) begin
      errors++; $display("FAIL wrap_summary beats=%0d lastdata=%0d count=%0d required 56 155 0", ct_out_n - base, ct_out_last[36:5], ct_count);
    end
  endtask

  task automatic test_packet();
    logic [3:0] keeps [3] = '{4'hF, 4'hF, 4'h3};
    int base = pm_out_n;
    for (int i = 0; i < 3; i++) begin
      pm_drive(1, mk(32'hA0 + 32'(i), keeps[i], 1'(i == 2)), 1);
      checks++;
      if (pm_m_tvalid !== 1'b0) begin
        errors++; $display("FAIL pkt_hold beat=%0d m_tvalid=%b required 0", i, pm_m_tvalid);
      end
      tick();
    end
    pm_drive(0, '0, 1);
    checks++;
    if (pm_m_tvalid !== 1'b1 || pm_pkt_count !== 5'd1) begin
      errors++; $display("FAIL pkt_release m_tvalid=%b pkt_count=%0d required 1 1", pm_m_tvalid, pm_pkt_count);
    end
    for (int c = 0; c < 20 && q_pm.size() != 0; c++) begin
      pm_drive(0, '0, 1);
      checks++;
      if (pm_obs() !== pm_exp()) begin
        errors++; $display("FAIL pkt_drain cyc=%0d got=%h required=%h", c, pm_obs(), pm_exp());
      end
      tick();
    end
    checks++;
    if (pm_out_n - base !== 3 || pm_out_last !== mk(32'hA2, 4'h3, 1'b1) || pm_pkt_count !== 5'd0) begin
      errors++; $display("FAIL pkt_summary beats=%0d last=%h pkt_count=%0d required 3 %h 0", pm_out_n - base, pm_out_last, pm_pkt_count, mk(32'hA2, 4'h3, 1'b1));
    end
  endtask

  task automatic test_oversize();
    int idx = 0;
    int base = pm_out_n;
    int first_cnt = -1;
    for (int c = 0; c < 200 && (idx < 20 || q_pm.size() != 0); c++) begin
      if (idx < 20) pm_drive(1, mk(32'h200 + 32'(idx), 4'hF, 1'(idx == 19)), 1);
      else pm_drive(0, '0, 1);
      if (idx < 20 && q_pm.size() != DEPTH) idx++;
      if (first_cnt < 0 && pm_m_tvalid === 1'b1) first_cnt = int'(pm_count);
      checks++;
      if (pm_obs() !== pm_exp()) begin
        errors++; $display("FAIL oversize cyc=%0d got=%h required=%h", c, pm_obs(), pm_exp());
      end
      tick();
    end
    checks++;
    if (first_cnt !== 16 || pm_out_n - base !== 20 || pm_out_last[36:5] !== 32'h213 || pm_out_last[0] !== 1'b1) begin
      errors++; $display("FAIL oversize_summary first_count=%0d beats=%0d last=%h required 16 20 213/last", first_cnt, pm_out_n - base, pm_out_last);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) begin
      pm_drive(1, mk(32'h300 + 32'(i), 4'hF, 1'(i == 0)), 0);
      tick();
    end
    pm_drive(1, mk(32'h3FF, 4'h1, 1'b1), 1);
    checks++;
    if (pm_count !== 5'd8 || pm_pkt_count !== 5'd1 || pm_m_tvalid !== 1'b1 || pm_m_tlast !== 1'b1) begin
      errors++; $display("FAIL simul_setup count=%0d pkt=%0d valid=%b last=%b required 8 1 1 1", pm_count, pm_pkt_count, pm_m_tvalid, pm_m_tlast);
    end
    tick();
    pm_drive(0, '0, 0);
    checks++;
    if (pm_count !== 5'd8 || pm_pkt_count !== 5'd1) begin
      errors++; $display("FAIL simul_both count=%0d pkt=%0d required 8 1", pm_count, pm_pkt_count);
    end
    for (int c = 0; c < 40 && q_pm.size() != 0; c++) begin
      pm_drive(0, '0, 1);
      checks++;
      if (pm_obs() !== pm_exp()) begin
        errors++; $display("FAIL simul_drain cyc=%0d got=%h required=%h", c, pm_obs(), pm_exp());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      ct_drive(1, mk(32'h50 + 32'(i), 4'hF, 1'(i == 2)), 0);
      tick();
    end
    ct_drive(0, '0, 0);
    checks++;
    if (ct_count !== 5'd5) begin
      errors++; $display("FAIL rstmid_pre count=%0d required 5", ct_count);
    end
    ct_rst = 1'b1;
    ct_drive(0, '0, 0);
    tick();
    ct_drive(0, '0, 0);
    checks++;
    if (ct_count !== 5'd0 || ct_pkt_count !== 5'd0 || ct_m_tvalid !== 1'b0 || ct_s_tready !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear count=%0d pkt=%0d valid=%b ready=%b required 0 0 0 0", ct_count, ct_pkt_count, ct_m_tvalid, ct_s_tready);
    end
    ct_rst = 1'b0;
    ct_drive(1, mk(32'hAA, 4'hF, 1'b1), 0);
    checks++;
    if (ct_s_tready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready ready=%b required 1", ct_s_tready);
    end
    tick();
    ct_drive(0, '0, 1);
    checks++;
    if (ct_m_tvalid !== 1'b1 || ct_m_tdata !== 32'hAA || ct_count !== 5'd1) begin
      errors++; $display("FAIL rstmid_first valid=%b data=%h count=%0d required 1 aa 1", ct_m_tvalid, ct_m_tdata, ct_count);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ct_drive(1'($urandom_range(0, 3) != 0), mk($urandom, 4'($urandom), 1'($urandom_range(0, 3) == 0)),
               1'($urandom_range(0, 2) != 0));
      pm_drive(1'($urandom_range(0, 3) != 0), mk($urandom, 4'($urandom), 1'($urandom_range(0, 5) == 0)),
               1'($urandom_range(0, 2) != 0));
      checks++;
      if (ct_obs() !== ct_exp()) begin
        errors++; $display("FAIL random_ct cyc=%0d got=%h required=%h", c, ct_obs(), ct_exp());
      end
      checks++;
      if (pm_obs() !== pm_exp()) begin
        errors++; $display("FAIL random_pm cyc=%0d got=%h required=%h", c, pm_obs(), pm_exp());
      end
      tick();
    end
  endtask

  initial begin
    ct_rst = 1'b1;
    pm_rst = 1'b1;
    ct_s_tvalid = 1'b0; ct_s_tdata = '0; ct_s_tkeep = '0; ct_s_tlast = 1'b0; ct_m_tready = 1'b0;
    pm_s_tvalid = 1'b0; pm_s_tdata = '0; pm_s_tkeep = '0; pm_s_tlast = 1'b0; pm_m_tready = 1'b0;
    ct_out_last = '0;
    pm_out_last = '0;
    @(negedge clk);
    test_reset();
    test_cut_through();
    test_fill_wrap();
    test_packet();
    test_oversize();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
